// File: rtl/rle_pkg.sv
// Shared constants and FSM state types for the scanline RLE decoder.
// Framing check is enabled by defining RLE_LINE_DECODER_FRAMING_CHECK_EN.
package rle_pkg;
  localparam logic       MARKING   = 1'b1;
  localparam logic       START_BIT = 1'b0;
  localparam logic       STOP_BIT  = 1'b1;
  localparam logic [7:0] EOL_BYTE  = 8'h00;

  localparam logic WHITE = 1'b0;
  localparam logic BLACK = 1'b1;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_t;

  typedef enum logic [1:0] {
    OUT_WAIT,
    OUT_EMIT,
    OUT_RELEASE
  } out_state_t;
endpackage

// File: rtl/rle_uart_rx.sv
// Async serial receiver: rxd synchronizer, bit timer and frame FSM.
// With RLE_LINE_DECODER_FRAMING_CHECK_EN a bad stop bit drops the frame and pulses frame_err.
module rle_uart_rx
  import rle_pkg::*;
#(
  parameter int BIT_CYCLES  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rxd,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);
  localparam int CW = $clog2(BIT_CYCLES);
  localparam logic [CW-1:0] HALF_LOAD = CW'(BIT_CYCLES / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(BIT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   rxs, rxs_d;
  rx_state_t              state;
  logic [CW-1:0]          cnt;
  logic [2:0]             bitn;
  logic [7:0]             shreg;
  logic                   stop_sample;

  assign rxs         = sync[SYNC_STAGES-1];
  assign stop_sample = (state == RX_STOP) && (cnt == '0);

`ifdef RLE_LINE_DECODER_FRAMING_CHECK_EN
  assign frame_err = stop_sample && (rxs != STOP_BIT);
`else
  assign frame_err = 1'b0;
`endif

  // Decoded from state so the holding register is written in the stop-sample cycle.
  assign byte_valid = stop_sample && !frame_err;
  assign byte_data  = shreg;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync  <= '1;
      rxs_d <= MARKING;
      state <= RX_IDLE;
      cnt   <= '0;
      bitn  <= '0;
      shreg <= '0;
    end else begin
      sync  <= (sync << 1) | SYNC_STAGES'(rxd);
      rxs_d <= rxs;
      case (state)
        RX_IDLE:
          if (rxs_d == MARKING && rxs == START_BIT) begin
            state <= RX_START;
            cnt   <= HALF_LOAD;
          end
        RX_START:
          if (cnt != '0) cnt <= cnt - 1'b1;
          else if (rxs != START_BIT) state <= RX_IDLE;
          else begin
            state <= RX_DATA;
            cnt   <= FULL_LOAD;
            bitn  <= '0;
          end
        RX_DATA:
          if (cnt != '0) cnt <= cnt - 1'b1;
          else begin
            shreg <= {rxs, shreg[7:1]};
            cnt   <= FULL_LOAD;
            if (bitn == 3'd7) state <= RX_STOP;
            else bitn <= bitn + 1'b1;
          end
        RX_STOP:
          if (cnt != '0) cnt <= cnt - 1'b1;
          else state <= frame_err ? RX_BREAK : RX_IDLE;
        // Line is stuck low after a bad stop bit; re-arm only once it marks again.
        RX_BREAK:
          if (rxs == MARKING) state <= RX_IDLE;
        default: state <= RX_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/rle_line_decoder.sv
// Expands received {N, C} run frames into pixel tokens over a dav_/rfd handshake.
// Optional stop-bit framing check: RLE_LINE_DECODER_FRAMING_CHECK_EN.
module rle_line_decoder
  import rle_pkg::*;
#(
  parameter int BIT_CYCLES  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic rxd,
  input  logic rfd,
  output logic dav_,
  output logic colore,
  output logic endline,
  output logic ovr,
  output logic ferr
);
  logic       byte_valid, frame_err;
  logic [7:0] byte_data;

  rle_uart_rx #(
    .BIT_CYCLES (BIT_CYCLES),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rx (
    .clock     (clock),
    .reset     (reset),
    .rxd       (rxd),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err)
  );

  assign ferr = frame_err;

  logic       hold_full, hold_take;
  logic [7:0] hold_data;
  out_state_t state;
  logic [6:0] run_cnt;

  assign hold_take = (state == OUT_WAIT) && hold_full;

  // A frame landing in the same cycle the holding register drains is accepted.
  always_ff @(posedge clock) begin
    if (reset) begin
      hold_full <= 1'b0;
      hold_data <= '0;
      ovr       <= 1'b0;
    end else if (byte_valid && (!hold_full || hold_take)) begin
      hold_full <= 1'b1;
      hold_data <= byte_data;
    end else begin
      if (hold_take)  hold_full <= 1'b0;
      if (byte_valid) ovr       <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= OUT_WAIT;
      run_cnt <= '0;
      dav_    <= 1'b1;
      colore  <= WHITE;
      endline <= 1'b0;
    end else begin
      case (state)
        OUT_WAIT:
          if (hold_full) begin
            if (hold_data == EOL_BYTE) begin
              run_cnt <= 7'd1;
              colore  <= WHITE;
              endline <= 1'b1;
              dav_    <= 1'b0;
              state   <= OUT_EMIT;
            end else if (hold_data[7:1] != '0) begin
              run_cnt <= hold_data[7:1];
              colore  <= hold_data[0];
              endline <= 1'b0;
              dav_    <= 1'b0;
              state   <= OUT_EMIT;
            end
            // Zero-length black run (0x01) is consumed silently.
          end
        OUT_EMIT:
          if (!rfd) begin
            dav_  <= 1'b1;
            state <= OUT_RELEASE;
          end
        OUT_RELEASE:
          if (rfd) begin
            run_cnt <= run_cnt - 1'b1;
            if (run_cnt == 7'd1) state <= OUT_WAIT;
            else begin
              dav_  <= 1'b0;
              state <= OUT_EMIT;
            end
          end
        default: begin
          state <= OUT_WAIT;
          dav_  <= 1'b1;
        end
      endcase
    end
  end
endmodule
